pwm_setpoint_ramp: RTL

- Upstream configuration stage for the PWM generator. It drives the generator's period, duty-cycle and enable inputs.
- Accepts new period/duty targets over a valid/ready handshake and validates them against the generator's legality rules (duty > 0, duty < period).
- Applies a new period only at a PWM period boundary, then slews duty toward the target in fixed steps, one step per N periods.
- This prevents runt or glitched pulses on the generator output.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/ramp_tick_div.sv | 27 ++
 rtl/pwm_setpoint_ramp.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared states, reset values and setpoint legality for the PWM setpoint ramp
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        RAMP      = 2'd2
    } state_t;

    localparam int PWM_MIN_PERIOD = 2;
    localparam int RST_PERIOD     = 2;
    localparam int RST_DUTY       = 1;

    // A setpoint the generator can run without producing runt or stuck pulses.
    function automatic logic setpoint_legal(input logic [31:0] period, input logic [31:0] duty);
        return (period >= 32'(PWM_MIN_PERIOD)) && (duty >= 32'd1) && (duty < period);
    endfunction

endpackage

// File: rtl/ramp_tick_div.sv
// rtl/ramp_tick_div.sv - divides PWM update points down to ramp ticks
module ramp_tick_div #(
    parameter int RAMP_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic adv,
    output logic tick
);

    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(RAMP_DIV - 1);

    logic [CW-1:0] count;

    assign tick = adv && !clear && (count == LAST);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (adv) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_setpoint_ramp.sv
// rtl/pwm_setpoint_ramp.sv - validates PWM setpoints, applies period on boundaries, slews duty
module pwm_setpoint_ramp
    import pwm_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int RAMP_STEP = 1,
    parameter int RAMP_DIV  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    input  logic             enable_in,
    input  logic [WIDTH-1:0] pwm_count,
    output logic [WIDTH-1:0] pwm_period,
    output logic [WIDTH-1:0] pwm_duty,
    output logic             pwm_en,
    output logic             busy,
    output logic             cfg_err
);

    localparam logic [WIDTH:0] STEP_W1 = (WIDTH + 1)'(RAMP_STEP);

    state_t           state;
    logic [WIDTH-1:0] tgt_period;
    logic [WIDTH-1:0] tgt_duty;
    logic             boundary;
    logic             adv;
    logic             tick;
    logic             xfer;
    logic             legal;
    logic [WIDTH-1:0] clamp_duty;
    logic [WIDTH-1:0] next_duty;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_floor;

    // A stopped generator has no pulse to glitch, so every cycle is an update point.
    assign boundary  = pwm_en && (pwm_count == pwm_period);
    assign adv       = boundary || !pwm_en;
    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign xfer      = cfg_valid && cfg_ready;
    assign legal     = setpoint_legal(32'(cfg_period), 32'(cfg_duty));

    always_comb begin
        clamp_duty = pwm_duty;
        if (pwm_duty >= tgt_period) begin
            clamp_duty = tgt_period - 1'b1;
        end
    end

    // One extra bit keeps the step from wrapping before it is clamped to the target.
    always_comb begin
        next_duty = pwm_duty;
        up_sum    = {1'b0, pwm_duty} + STEP_W1;
        dn_floor  = {1'b0, tgt_duty} + STEP_W1;
        if (pwm_duty < tgt_duty) begin
            next_duty = (up_sum >= {1'b0, tgt_duty}) ? tgt_duty : up_sum[WIDTH-1:0];
        end else if (pwm_duty > tgt_duty) begin
            next_duty = ({1'b0, pwm_duty} <= dn_floor) ? tgt_duty
                                                        : pwm_duty - WIDTH'(RAMP_STEP);
        end
    end

    ramp_tick_div #(
        .RAMP_DIV (RAMP_DIV)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .clear (state != RAMP),
        .adv   (adv),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            pwm_period <= WIDTH'(RST_PERIOD);
            pwm_duty   <= WIDTH'(RST_DUTY);
            pwm_en     <= 1'b0;
            cfg_err    <= 1'b0;
            tgt_period <= '0;
            tgt_duty   <= '0;
        end else begin
            pwm_en  <= enable_in;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (legal) begin
                            tgt_period <= cfg_period;
                            tgt_duty   <= cfg_duty;
                            state      <= WAIT_EDGE;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                WAIT_EDGE: begin
                    if (adv) begin
                        pwm_period <= tgt_period;
                        pwm_duty   <= clamp_duty;
                        state      <= RAMP;
                    end
                end
                RAMP: begin
                    if (pwm_duty == tgt_duty) begin
                        state <= IDLE;
                    end else if (tick) begin
                        pwm_duty <= next_duty;
                        if (next_duty == tgt_duty) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
